// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and I-cache handshake.
// Optional macro FETCH_HLT_DETECT_EN: halt fetch locally on a captured HLT opcode (4'hF).
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  input  logic        hltIn,
  output logic [15:0] iAddr,
  output logic        iRdEn,
  input  logic [15:0] iData,
  input  logic        iRdy,
  output logic [15:0] ifIdInstr,
  output logic [15:0] ifIdPcPlus1,
  output logic        ifIdValid,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, MISS, DRAIN, HALT} stateT;

  stateT       state, nState;
  logic [15:0] pc, nPc;
  logic [15:0] drainAddr, nDrainAddr;
  logic        haltPending, nHaltPending;
  logic        skidValid, nSkidValid;
  logic [15:0] skidInstr, nSkidInstr;
  logic [15:0] skidPcPlus1, nSkidPcPlus1;
  logic [15:0] nIfIdInstr, nIfIdPcPlus1;
  logic        nIfIdValid;

  logic [15:0] pcPlus1;
  logic        fetchHit, outstanding, hltHit;

  assign pcPlus1     = pc + 16'd1;
  assign fetchHit    = iRdEn && iRdy && (state == RUN || state == MISS);
  assign outstanding = iRdEn && !iRdy;

`ifdef FETCH_HLT_DETECT_EN
  assign hltHit = (iData[15:12] == 4'hF);
`else
  assign hltHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      drainAddr   <= '0;
      haltPending <= 1'b0;
      skidValid   <= 1'b0;
      skidInstr   <= NOP_INSTR;
      skidPcPlus1 <= '0;
      ifIdInstr   <= NOP_INSTR;
      ifIdPcPlus1 <= '0;
      ifIdValid   <= 1'b0;
    end else begin
      state       <= nState;
      pc          <= nPc;
      drainAddr   <= nDrainAddr;
      haltPending <= nHaltPending;
      skidValid   <= nSkidValid;
      skidInstr   <= nSkidInstr;
      skidPcPlus1 <= nSkidPcPlus1;
      ifIdInstr   <= nIfIdInstr;
      ifIdPcPlus1 <= nIfIdPcPlus1;
      ifIdValid   <= nIfIdValid;
    end
  end

  // Priority: hltIn > local HLT detect > redirect > drain completion > stall > normal fetch.
  // An outstanding request (iRdEn && !iRdy) is always parked in DRAIN so the bus stays stable.
  always_comb begin
    nState       = state;
    nPc          = pc;
    nDrainAddr   = drainAddr;
    nHaltPending = haltPending;
    nSkidValid   = skidValid;
    nSkidInstr   = skidInstr;
    nSkidPcPlus1 = skidPcPlus1;
    nIfIdInstr   = ifIdInstr;
    nIfIdPcPlus1 = ifIdPcPlus1;
    nIfIdValid   = ifIdValid;
    if (state == HALT) begin
      if (hltIn || (!stall && !skidValid)) begin
        nIfIdInstr = NOP_INSTR;
        nIfIdValid = 1'b0;
        nSkidValid = 1'b0;
      end else if (!stall) begin
        nIfIdInstr   = skidInstr;
        nIfIdPcPlus1 = skidPcPlus1;
        nIfIdValid   = 1'b1;
        nSkidValid   = 1'b0;
      end
    end else if (hltIn) begin
      nIfIdInstr = NOP_INSTR;
      nIfIdValid = 1'b0;
      nSkidValid = 1'b0;
      if (outstanding) begin
        nState       = DRAIN;
        nHaltPending = 1'b1;
        if (state != DRAIN) nDrainAddr = pc;
      end else begin
        nState       = HALT;
        nHaltPending = 1'b0;
      end
    end else if (fetchHit && hltHit) begin
      nPc    = pcPlus1;
      nState = HALT;
      if (stall) begin
        nSkidValid   = 1'b1;
        nSkidInstr   = iData;
        nSkidPcPlus1 = pcPlus1;
      end else begin
        nIfIdInstr   = iData;
        nIfIdPcPlus1 = pcPlus1;
        nIfIdValid   = 1'b1;
      end
    end else if (redirect) begin
      nPc        = redirectPc;
      nIfIdInstr = NOP_INSTR;
      nIfIdValid = 1'b0;
      nSkidValid = 1'b0;
      if (outstanding) begin
        nState = DRAIN;
        if (state != DRAIN) nDrainAddr = pc;
      end else if (state == DRAIN) begin
        nState       = haltPending ? HALT : RUN;
        nHaltPending = 1'b0;
      end else begin
        nState = RUN;
      end
    end else if (state == DRAIN) begin
      if (!stall) begin
        nIfIdInstr = NOP_INSTR;
        nIfIdValid = 1'b0;
      end
      if (iRdy) begin
        nState       = haltPending ? HALT : RUN;
        nHaltPending = 1'b0;
      end
    end else if (stall) begin
      if (fetchHit) begin
        nSkidValid   = 1'b1;
        nSkidInstr   = iData;
        nSkidPcPlus1 = pcPlus1;
        nPc          = pcPlus1;
        nState       = RUN;
      end else if (outstanding) begin
        nState = MISS;
      end
    end else if (skidValid) begin
      nIfIdInstr   = skidInstr;
      nIfIdPcPlus1 = skidPcPlus1;
      nIfIdValid   = 1'b1;
      nSkidValid   = 1'b0;
    end else if (fetchHit) begin
      nIfIdInstr   = iData;
      nIfIdPcPlus1 = pcPlus1;
      nIfIdValid   = 1'b1;
      nPc          = pcPlus1;
      nState       = RUN;
    end else begin
      nIfIdInstr = NOP_INSTR;
      nIfIdValid = 1'b0;
      if (outstanding) nState = MISS;
    end
  end

  always_comb begin
    iRdEn  = 1'b0;
    iAddr  = pc;
    halted = 1'b0;
    case (state)
      RUN:   iRdEn = !skidValid;
      MISS:  iRdEn = 1'b1;
      DRAIN: begin
        iRdEn = 1'b1;
        iAddr = drainAddr;
      end
      HALT:  halted = 1'b1;
      default: ;
    endcase
    if (rst) iRdEn = 1'b0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus hand sequences for drain/halt/reset corners.
module tb_fetch_stage;

  logic        clk, rst;
  logic        stall, redirect, hltIn, iRdy, hltMem;
  logic [15:0] redirectPc;
  logic [15:0] iAddr, iData, ifIdInstr, ifIdPcPlus1;
  logic        iRdEn, ifIdValid, halted;

  logic        stall2, redirect2, hltIn2, iRdy2;
  logic [15:0] redirectPc2, iAddr2, iData2, ifIdInstr2, ifIdPcPlus12;
  logic        iRdEn2, ifIdValid2, halted2;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] memWord(input logic [15:0] a, input logic hm);
    if (hm && a == 16'h0003) return 16'hF000;
    return {4'h3, a[11:0]};
  endfunction

  assign iData  = memWord(iAddr, hltMem);
  assign iData2 = memWord(iAddr2, 1'b0);

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .hltIn(hltIn), .iAddr(iAddr), .iRdEn(iRdEn), .iData(iData), .iRdy(iRdy),
    .ifIdInstr(ifIdInstr), .ifIdPcPlus1(ifIdPcPlus1), .ifIdValid(ifIdValid), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2), .redirectPc(redirectPc2),
    .hltIn(hltIn2), .iAddr(iAddr2), .iRdEn(iRdEn2), .iData(iData2), .iRdy(iRdy2),
    .ifIdInstr(ifIdInstr2), .ifIdPcPlus1(ifIdPcPlus12), .ifIdValid(ifIdValid2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        hltIn;
    logic        iRdy;
    logic [15:0] expAddr;
    logic        expRdEn;
    logic        expValid;
    logic [15:0] expPp1;
    logic        expHalted;
  } vecT;

  vecT vecs[25];

  function automatic vecT mk(input logic s, input logic r, input logic [15:0] rp, input logic h,
                             input logic rdy, input logic [15:0] ea, input logic er,
                             input logic ev, input logic [15:0] ep, input logic eh);
    vecT v;
    v.stall = s; v.redirect = r; v.redirectPc = rp; v.hltIn = h; v.iRdy = rdy;
    v.expAddr = ea; v.expRdEn = er; v.expValid = ev; v.expPp1 = ep; v.expHalted = eh;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] rp, input logic h,
                       input logic rdy);
    @(posedge clk);
    #1;
    stall = s; redirect = r; redirectPc = rp; hltIn = h; iRdy = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0; hltIn = 1'b0; iRdy = 1'b1;
    hltMem = 1'b0;
    stall2 = 1'b0; redirect2 = 1'b0; redirectPc2 = '0; hltIn2 = 1'b0; iRdy2 = 1'b1;

    //           stall redir rpc    hlt rdy | addr   rdEn val pp1    halted
    vecs[0]  = mk(0, 0, 16'h0,  0, 1, 16'h00, 1, 0, 16'h00, 0);
    vecs[1]  = mk(0, 0, 16'h0,  0, 1, 16'h01, 1, 1, 16'h01, 0);
    vecs[2]  = mk(0, 0, 16'h0,  0, 1, 16'h02, 1, 1, 16'h02, 0);
    vecs[3]  = mk(0, 0, 16'h0,  0, 1, 16'h03, 1, 1, 16'h03, 0);
    vecs[4]  = mk(0, 0, 16'h0,  0, 1, 16'h04, 1, 1, 16'h04, 0);
    vecs[5]  = mk(0, 0, 16'h0,  0, 0, 16'h05, 1, 1, 16'h05, 0);
    vecs[6]  = mk(0, 0, 16'h0,  0, 0, 16'h05, 1, 0, 16'h00, 0);
    vecs[7]  = mk(0, 0, 16'h0,  0, 0, 16'h05, 1, 0, 16'h00, 0);
    vecs[8]  = mk(0, 0, 16'h0,  0, 1, 16'h05, 1, 0, 16'h00, 0);
    vecs[9]  = mk(0, 0, 16'h0,  0, 1, 16'h06, 1, 1, 16'h06, 0);
    vecs[10] = mk(1, 0, 16'h0,  0, 1, 16'h07, 1, 1, 16'h07, 0);
    vecs[11] = mk(1, 0, 16'h0,  0, 1, 16'h08, 0, 1, 16'h07, 0);
    vecs[12] = mk(0, 0, 16'h0,  0, 1, 16'h08, 0, 1, 16'h07, 0);
    vecs[13] = mk(0, 0, 16'h0,  0, 1, 16'h08, 1, 1, 16'h08, 0);
    vecs[14] = mk(0, 1, 16'h10, 0, 1, 16'h09, 1, 1, 16'h09, 0);
    vecs[15] = mk(0, 0, 16'h0,  0, 0, 16'h10, 1, 0, 16'h00, 0);
    vecs[16] = mk(0, 1, 16'h40, 0, 0, 16'h10, 1, 0, 16'h00, 0);
    vecs[17] = mk(0, 0, 16'h0,  0, 0, 16'h10, 1, 0, 16'h00, 0);
    vecs[18] = mk(0, 0, 16'h0,  0, 1, 16'h10, 1, 0, 16'h00, 0);
    vecs[19] = mk(0, 0, 16'h0,  0, 1, 16'h40, 1, 0, 16'h00, 0);
    vecs[20] = mk(0, 0, 16'h0,  0, 1, 16'h41, 1, 1, 16'h41, 0);
    vecs[21] = mk(0, 1, 16'h80, 1, 1, 16'h42, 1, 1, 16'h42, 0);
    vecs[22] = mk(0, 0, 16'h0,  0, 1, 16'h42, 0, 0, 16'h00, 1);
    vecs[23] = mk(0, 1, 16'h20, 0, 1, 16'h42, 0, 0, 16'h00, 1);
    vecs[24] = mk(0, 0, 16'h0,  0, 1, 16'h42, 0, 0, 16'h00, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_iRdEn", iRdEn, 1'b0);
    check16("rst_iAddr", iAddr, 16'h0000);
    check1("rst_valid", ifIdValid, 1'b0);
    check16("rst_instr", ifIdInstr, 16'h0000);
    check16("rst_pp1", ifIdPcPlus1, 16'h0000);
    check1("rst_halted", halted, 1'b0);

    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirectPc = vecs[i].redirectPc;
      hltIn = vecs[i].hltIn; iRdy = vecs[i].iRdy;
      @(negedge clk);
      check16($sformatf("row%0d_iAddr", i), iAddr, vecs[i].expAddr);
      check1($sformatf("row%0d_iRdEn", i), iRdEn, vecs[i].expRdEn);
      check1($sformatf("row%0d_valid", i), ifIdValid, vecs[i].expValid);
      check1($sformatf("row%0d_halted", i), halted, vecs[i].expHalted);
      if (vecs[i].expValid) begin
        check16($sformatf("row%0d_pp1", i), ifIdPcPlus1, vecs[i].expPp1);
        check16($sformatf("row%0d_instr", i), ifIdInstr, memWord(vecs[i].expPp1 - 16'd1, 1'b0));
      end
    end

    // Reset while halted, then hltIn during a miss must drain before halting.
    @(posedge clk);
    #1;
    rst = 1'b1; redirect = 1'b0; hltIn = 1'b0; iRdy = 1'b0;
    @(negedge clk);
    check16("midhalt_rst_iAddr", iAddr, 16'h0000);
    check1("midhalt_rst_halted", halted, 1'b0);
    check1("midhalt_rst_iRdEn", iRdEn, 1'b0);
    check16("wrap_rst_iAddr", iAddr2, 16'hFFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check16("drain_c0_iAddr", iAddr, 16'h0000);
    check1("drain_c0_iRdEn", iRdEn, 1'b1);
    check1("wrap_c0_iRdEn", iRdEn2, 1'b1);
    drive(0, 0, 16'h0, 1, 0);
    check16("wrap_pp1", ifIdPcPlus12, 16'h0000);
    check1("wrap_valid", ifIdValid2, 1'b1);
    check16("wrap_instr", ifIdInstr2, 16'h3FFF);
    check16("wrap_next_iAddr", iAddr2, 16'h0000);
    check1("wrap_halted", halted2, 1'b0);
    drive(0, 0, 16'h0, 0, 0);
    check16("drain_hold_iAddr", iAddr, 16'h0000);
    check1("drain_hold_iRdEn", iRdEn, 1'b1);
    check1("drain_hold_halted", halted, 1'b0);
    drive(0, 0, 16'h0, 0, 1);
    check1("drain_done_iRdEn", iRdEn, 1'b1);
    check1("drain_done_valid", ifIdValid, 1'b0);
    drive(0, 0, 16'h0, 0, 1);
    check1("drain_halt_iRdEn", iRdEn, 1'b0);
    check1("drain_halt_halted", halted, 1'b1);

`ifdef FETCH_HLT_DETECT_EN
    @(posedge clk);
    #1;
    rst = 1'b1; hltMem = 1'b1; iRdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      check16($sformatf("hlt_fetch%0d_iAddr", c), iAddr, c[15:0]);
      check1($sformatf("hlt_fetch%0d_iRdEn", c), iRdEn, 1'b1);
      drive(0, 0, 16'h0, 0, 1);
    end
    check1("hlt_det_iRdEn", iRdEn, 1'b0);
    check1("hlt_det_halted", halted, 1'b1);
    check1("hlt_det_valid", ifIdValid, 1'b1);
    check16("hlt_det_instr", ifIdInstr, 16'hF000);
    check16("hlt_det_pp1", ifIdPcPlus1, 16'h0004);
    drive(0, 1, 16'h0030, 0, 1);
    check1("hlt_redir_iRdEn", iRdEn, 1'b0);
    drive(0, 0, 16'h0, 0, 1);
    check16("hlt_redir_iAddr", iAddr, 16'h0004);
    check1("hlt_redir_halted", halted, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
